// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Purpose: receives a program image as a byte stream over a valid/ready
// handshake and writes it into the instruction memory one 32-bit word at a
// time. Bytes are assembled little-endian. The core is held (cpu_hold) for
// the whole load.
//
// Image format: one length byte N (word count, 0..DEPTH), followed by 4*N
// data bytes. When LOADER_CHECKSUM_EN is defined, one more byte follows the
// data. That byte must equal the XOR of all data bytes.
//
// Optional feature macro: LOADER_CHECKSUM_EN (trailing checksum byte check).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a load (only honoured when idle)
//   rx_data    in   incoming byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  loader accepts a byte this cycle (depends on state only)
//   mem_we     out  instruction memory write enable, one cycle per word
//   mem_addr   out  write address (byte address)
//   mem_wdata  out  write data
//   busy       out  load in progress
//   cpu_hold   out  stall request to the core, equal to busy
//   done       out  one-cycle pulse when a load completes successfully
//   error      out  sticky error flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CHECK = 3'd5
`endif
    } state_t;

    // State entered once the last word has been written (or for N=0).
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FINISH      = S_CHECK;
    localparam logic   FINISH_CHECKS = 1'b1;
`else
    localparam state_t S_FINISH      = S_DONE;
    localparam logic   FINISH_CHECKS = 1'b0;
`endif

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
    // Running checksum over the data bytes: plain byte-wise XOR.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_t      state_q,    state_d;
    logic [7:0]  len_q,      len_d;
    logic [7:0]  idx_q,      idx_d;
    logic [1:0]  bcnt_q,     bcnt_d;
    logic [23:0] asm_q,      asm_d;
    logic        rx_ready_q, rx_ready_d;
    logic        mem_we_q,   mem_we_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        error_q,    error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q,     csum_d;
`endif

    logic accept_s;

    // A byte moves only when both sides agree in the same cycle.
    assign accept_s = rx_valid & rx_ready_q;

    // Next-state and next-output logic; every output is registered so that
    // it reflects the state being entered.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        asm_d      = asm_q;
        rx_ready_d = rx_ready_q;
        mem_we_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d    = 1'b0;
                    idx_d      = 8'd0;
                    bcnt_d     = 2'd0;
                    asm_d      = 24'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                    state_d    = S_LEN;
                    rx_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    rx_ready_d = 1'b0;
                    busy_d     = 1'b0;
                end
            end
            S_LEN: begin
                if (accept_s) begin
                    len_d = rx_data;
                    if (rx_data == 8'd0) begin
                        state_d    = S_FINISH;
                        rx_ready_d = FINISH_CHECKS;
                        done_d     = ~FINISH_CHECKS;
                    end else if ({24'd0, rx_data} > DEPTH_W) begin
                        error_d    = 1'b1;
                        state_d    = S_IDLE;
                        rx_ready_d = 1'b0;
                        busy_d     = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (accept_s) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_next(csum_q, rx_data);
`endif
                    if (bcnt_q == 2'd3) begin
                        // 4th byte goes straight to the write data; the
                        // assembly register only ever holds bytes 0..2.
                        state_d    = S_WRITE;
                        rx_ready_d = 1'b0;
                        mem_we_d   = 1'b1;
                        addr_d     = BASE_ADDR + ({24'd0, idx_q} * ADDR_STEP);
                        wdata_d    = {rx_data, asm_q};
                        bcnt_d     = 2'd0;
                    end else begin
                        case (bcnt_q)
                            2'd0:    asm_d[7:0]   = rx_data;
                            2'd1:    asm_d[15:8]  = rx_data;
                            2'd2:    asm_d[23:16] = rx_data;
                            default: asm_d        = asm_q;
                        endcase
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 8'd1;
                if ((idx_q + 8'd1) == len_q) begin
                    state_d    = S_FINISH;
                    rx_ready_d = FINISH_CHECKS;
                    done_d     = ~FINISH_CHECKS;
                end else begin
                    state_d    = S_DATA;
                    rx_ready_d = 1'b1;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept_s) begin
                    rx_ready_d = 1'b0;
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Words already written stay in memory.
                        error_d = 1'b1;
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    state_d = S_CHECK;
                end
            end
`endif
            S_DONE: begin
                state_d    = S_IDLE;
                rx_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                rx_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset discards any partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= 8'd0;
            idx_q      <= 8'd0;
            bcnt_q     <= 2'd0;
            asm_q      <= 24'd0;
            rx_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            asm_q      <= asm_d;
            rx_ready_q <= rx_ready_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign cpu_hold  = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
